vga_rect_plot_sched: RTL and testbench

// - Shares the single-pixel plot port of the vga_adapter (160x120, 3-bit colour) between two

---
 rtl/vga_rect_plot_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_vga_rect_plot_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_plot_sched.sv
// vga_rect_plot_sched: round-robin scheduler that shares the vga_adapter
// single-pixel plot port between two rectangle-fill requesters.
// Each granted rectangle is drawn one pixel per clock in raster order.
// Pixels that fall outside the visible screen are clipped.
// Optional build macro CLEAR_ON_RESET_EN: after reset the whole screen is swept
// with colour 0 before any request is served.
//
// Handshake: req[i] is a level request. The requester holds req[i] and its
// parameters stable until ack[i] pulses. ack[i] pulses for one cycle in the
// same cycle as the first pixel. After ack the parameters may change. req[i]
// still high after done[i] counts as a new request.
module vga_rect_plot_sched #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [1:0]            req,
  input  logic [2*X_W-1:0]      req_x0,
  input  logic [2*Y_W-1:0]      req_y0,
  input  logic [2*X_W-1:0]      req_w,
  input  logic [2*Y_W-1:0]      req_h,
  input  logic [2*COLOUR_W-1:0] req_col,
  output logic [1:0]            ack,
  output logic [1:0]            done,
  output logic                  busy,
  output logic [X_W-1:0]        x,
  output logic [Y_W-1:0]        y,
  output logic [COLOUR_W-1:0]   colour,
  output logic                  plot,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_FIN   = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);
`ifdef CLEAR_ON_RESET_EN
  localparam logic [X_W-1:0] CLR_X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] CLR_Y_LAST = Y_W'(SCREEN_H - 1);
`endif

  state_t                state, state_n;
  logic                  last_grant, last_grant_n;
  logic                  gnt, gnt_n;
  logic [X_W-1:0]        rx0, rx0_n, rw, rw_n, cx, cx_n;
  logic [Y_W-1:0]        ry0, ry0_n, rh, rh_n, cy, cy_n;
  logic [COLOUR_W-1:0]   rcol, rcol_n;
  logic [1:0]            ack_n, done_n;
  logic                  busy_n, plot_n;
  logic [X_W-1:0]        x_n;
  logic [Y_W-1:0]        y_n;
  logic [COLOUR_W-1:0]   colour_n;

  // Pixel emitter inputs: base + offset, enable and colour
  logic                  emit;
  logic [X_W-1:0]        ex0, ecx;
  logic [Y_W-1:0]        ey0, ecy;
  logic [COLOUR_W-1:0]   ecol;
  logic [X_W:0]          px;
  logic [Y_W:0]          py;
  logic                  gsel;
  logic                  last_px;

  assign dbg_state = state;

  // Next-state, arbitration, raster counters and registered-output values
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    gnt_n        = gnt;
    rx0_n        = rx0;
    ry0_n        = ry0;
    rw_n         = rw;
    rh_n         = rh;
    rcol_n       = rcol;
    cx_n         = cx;
    cy_n         = cy;
    ack_n        = 2'b00;
    done_n       = 2'b00;
    plot_n       = 1'b0;
    x_n          = x;
    y_n          = y;
    colour_n     = colour;
    emit         = 1'b0;
    ex0          = rx0;
    ey0          = ry0;
    ecx          = '0;
    ecy          = '0;
    ecol         = rcol;
    gsel         = 1'b0;
    last_px      = 1'b0;
    px           = '0;
    py           = '0;

    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          // Both requesting: the one not served last time wins
          gsel         = (req == 2'b11) ? ~last_grant : req[1];
          rx0_n        = gsel ? req_x0[2*X_W-1:X_W]           : req_x0[X_W-1:0];
          ry0_n        = gsel ? req_y0[2*Y_W-1:Y_W]           : req_y0[Y_W-1:0];
          rw_n         = gsel ? req_w[2*X_W-1:X_W]            : req_w[X_W-1:0];
          rh_n         = gsel ? req_h[2*Y_W-1:Y_W]            : req_h[Y_W-1:0];
          rcol_n       = gsel ? req_col[2*COLOUR_W-1:COLOUR_W] : req_col[COLOUR_W-1:0];
          cx_n         = '0;
          cy_n         = '0;
          gnt_n        = gsel;
          last_grant_n = gsel;
          ack_n[gsel]  = 1'b1;
          state_n      = S_DRAW;
          // First pixel goes out together with ack
          emit         = (rw_n != '0) && (rh_n != '0);
          ex0          = rx0_n;
          ey0          = ry0_n;
          ecol         = rcol_n;
        end
      end
      S_DRAW: begin
        // cx/cy index the pixel currently on the outputs
        last_px = (rw == '0) || (rh == '0) ||
                  (((cx + 1'b1) == rw) && ((cy + 1'b1) == rh));
        if (last_px) begin
          state_n     = S_FIN;
          done_n[gnt] = 1'b1;
        end else begin
          if ((cx + 1'b1) == rw) begin
            cx_n = '0;
            cy_n = cy + 1'b1;
          end else begin
            cx_n = cx + 1'b1;
          end
          emit = 1'b1;
          ecx  = cx_n;
          ecy  = cy_n;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
`ifdef CLEAR_ON_RESET_EN
      S_CLEAR: begin
        emit = 1'b1;
        ex0  = '0;
        ey0  = '0;
        ecx  = cx;
        ecy  = cy;
        ecol = '0;
        if ((cx == CLR_X_LAST) && (cy == CLR_Y_LAST)) begin
          state_n = S_IDLE;
          cx_n    = '0;
          cy_n    = '0;
        end else if (cx == CLR_X_LAST) begin
          cx_n = '0;
          cy_n = cy + 1'b1;
        end else begin
          cx_n = cx + 1'b1;
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Shared pixel emitter with screen-edge clipping; outputs hold when not plotting
    px = {1'b0, ex0} + {1'b0, ecx};
    py = {1'b0, ey0} + {1'b0, ecy};
    if (emit && (px < SCR_W) && (py < SCR_H)) begin
      plot_n   = 1'b1;
      x_n      = px[X_W-1:0];
      y_n      = py[Y_W-1:0];
      colour_n = ecol;
    end

    // The cycle showing the final clear pixel still counts as busy
    busy_n = (state_n != S_IDLE) || (state == S_CLEAR);
  end

  // State and registered outputs; asynchronous reset abandons any rectangle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
`ifdef CLEAR_ON_RESET_EN
      state <= S_CLEAR;
`else
      state <= S_IDLE;
`endif
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      rx0        <= '0;
      ry0        <= '0;
      rw         <= '0;
      rh         <= '0;
      rcol       <= '0;
      cx         <= '0;
      cy         <= '0;
      ack        <= 2'b00;
      done       <= 2'b00;
      busy       <= 1'b0;
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      gnt        <= gnt_n;
      rx0        <= rx0_n;
      ry0        <= ry0_n;
      rw         <= rw_n;
      rh         <= rh_n;
      rcol       <= rcol_n;
      cx         <= cx_n;
      cy         <= cy_n;
      ack        <= ack_n;
      done       <= done_n;
      busy       <= busy_n;
      plot       <= plot_n;
      x          <= x_n;
      y          <= y_n;
      colour     <= colour_n;
    end
  end

endmodule

// File: tb/tb_vga_rect_plot_sched.sv
// tb_vga_rect_plot_sched: scoreboard bench for vga_rect_plot_sched.
// Each issued batch pushes its expected per-cycle output trace into exp_q;
// a monitor pops one record for every cycle in which the DUT shows activity.
module tb_vga_rect_plot_sched;

  logic        clock;
  logic        resetn;
  logic [1:0]  req;
  logic [15:0] req_x0, req_w;
  logic [13:0] req_y0, req_h;
  logic [5:0]  req_col;
  logic [1:0]  ack, done;
  logic        busy, plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic [1:0]  dbg_state;

  vga_rect_plot_sched dut (
    .clock(clock), .resetn(resetn), .req(req),
    .req_x0(req_x0), .req_y0(req_y0), .req_w(req_w), .req_h(req_h), .req_col(req_col),
    .ack(ack), .done(done), .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  // record = {ack[1:0], done[1:0], busy, plot, x[7:0], y[6:0], colour[2:0]}
  logic [23:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // reference model state
  int          m_last;     // requester served most recently
  logic [7:0]  mx;
  logic [6:0]  my;
  logic [2:0]  mc;
  int          px0[2], py0[2], pw[2], ph[2], pcol[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1;
    mx = '0;
    my = '0;
    mc = '0;
  endtask

  // Expected trace of one rectangle: max(w*h,1) draw cycles then one finish cycle
  task automatic push_rect(input int g);
    int n, cxi, cyi, xx, yy;
    logic p;
    logic [1:0] a;
    n = (pw[g] == 0 || ph[g] == 0) ? 1 : pw[g] * ph[g];
    for (int k = 0; k < n; k++) begin
      p = 1'b0;
      if (pw[g] != 0 && ph[g] != 0) begin
        cxi = k % pw[g];
        cyi = k / pw[g];
        xx  = px0[g] + cxi;
        yy  = py0[g] + cyi;
        if (xx < 160 && yy < 120) begin
          p  = 1'b1;
          mx = 8'(xx);
          my = 7'(yy);
          mc = 3'(pcol[g]);
        end
      end
      a = (k == 0) ? 2'(1 << g) : 2'b00;
      exp_q.push_back({a, 2'b00, 1'b1, p, mx, my, mc});
    end
    exp_q.push_back({2'b00, 2'(1 << g), 1'b1, 1'b0, mx, my, mc});
    m_last = g;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_p(input int i, input int x0, input int y0, input int w, input int h, input int c);
    px0[i] = x0; py0[i] = y0; pw[i] = w; ph[i] = h; pcol[i] = c;
    req_x0[i*8 +: 8]  = 8'(x0);
    req_y0[i*7 +: 7]  = 7'(y0);
    req_w[i*8 +: 8]   = 8'(w);
    req_h[i*7 +: 7]   = 7'(h);
    req_col[i*3 +: 3] = 3'(c);
  endtask

  // Issue req=mask from an idle DUT, wait for every ack and done, then for idle
  task automatic run_batch(input logic [1:0] mask);
    logic [1:0] pending;
    int dones_left, cycles;
    bit first_ack;
    if (mask == 2'b11) begin
      if (m_last == 1) begin push_rect(0); push_rect(1); end
      else             begin push_rect(1); push_rect(0); end
    end else begin
      push_rect(mask[1] ? 1 : 0);
    end
    pending    = mask;
    dones_left = (mask == 2'b11) ? 2 : 1;
    cycles     = 0;
    first_ack  = 1'b1;
    @(negedge clock);
    req = mask;
    while ((pending != 2'b00 || dones_left > 0) && cycles < 400) begin
      @(posedge clock); #1;
      cycles++;
      if (first_ack && ack != 2'b00) begin
        check("ack_latency", 32'(cycles), 32'd1);
        first_ack = 1'b0;
      end
      pending    = pending & ~ack;
      dones_left = dones_left - int'(done[0]) - int'(done[1]);
      @(negedge clock);
      req = req & pending;
    end
    req = 2'b00;
    if (cycles >= 400) begin
      n_checks++; n_fail++;
      $display("FAIL batch_timeout mask=%b pending=%b dones_left=%0d", mask, pending, dones_left);
    end
    cycles = 0;
    do begin
      @(posedge clock); #1;
      cycles++;
    end while (busy && cycles < 50);
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout busy=%b required 0", busy);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [23:0] act, e;
    forever begin
      @(posedge clock); #1;
      if (resetn && (busy || plot || ack != 2'b00 || done != 2'b00)) begin
        act = {ack, done, busy, plot, x, y, colour};
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL trace act=%h exp=<none>", act);
        end else begin
          e = exp_q.pop_front();
          check("trace", 32'(act), 32'(e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int m, xx, yy;
    resetn  = 1'b0;
    req     = 2'b00;
    req_x0  = '0; req_y0 = '0; req_w = '0; req_h = '0; req_col = '0;
    model_reset();
    repeat (3) @(negedge clock);
    #1;
    check("reset_outputs", 32'({ack, done, busy, plot, x, y, colour}), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Both requesters at once: req0 first after reset, and again next round
    set_p(0, 5, 5, 1, 1, 1);
    set_p(1, 6, 7, 1, 1, 2);
    run_batch(2'b11);
    set_p(0, 40, 50, 1, 1, 5);
    set_p(1, 41, 51, 1, 1, 6);
    run_batch(2'b11);
    // Only req1, twice in a row
    set_p(1, 70, 80, 2, 1, 3);
    run_batch(2'b10);
    set_p(1, 71, 81, 1, 2, 7);
    run_batch(2'b10);
    // Basic 3x2 fill
    set_p(0, 10, 20, 3, 2, 4);
    run_batch(2'b01);
    // Clipping at the bottom-right corner
    set_p(1, 158, 119, 4, 2, 2);
    run_batch(2'b10);
    // Degenerate width and height
    set_p(0, 30, 30, 0, 5, 6);
    run_batch(2'b01);
    set_p(1, 30, 30, 4, 0, 1);
    run_batch(2'b10);

    // Randomized batches
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < 2; r++) begin
        xx = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
        yy = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119);
        set_p(r, xx, yy, $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 7));
      end
      m = $urandom_range(1, 3);
      run_batch(2'(m));
    end

    // Asynchronous reset in the middle of a 10x10 rectangle
    set_p(0, 20, 30, 10, 10, 5);
    push_rect(0);
    @(negedge clock);
    req = 2'b01;
    @(negedge clock);
    req = 2'b00;
    repeat (20) @(negedge clock);
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset", 32'({ack, done, busy, plot}), 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    set_p(1, 3, 4, 2, 2, 6);
    set_p(0, 90, 60, 3, 1, 2);
    run_batch(2'b11);

    repeat (5) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
